// File: rtl/seq_divider.sv
// seq_divider: sequential radix-2 non-restoring divider, one quotient bit per clock.
//
// A request (dividend, divisor) is accepted on start_valid & start_ready (IDLE only).
// A zero divisor goes straight to DONE with quotient = all ones, remainder = dividend
// and div_by_zero = 1. Otherwise the unit runs WIDTH RUN steps and one FIX step.
// The result is then held on quotient/remainder/div_by_zero with out_valid high until
// out_ready is seen. All arithmetic shares one WIDTH+1-bit carry-lookahead adder.
//
// Optional macro DIV_SIGNED_EN: two's-complement operands, truncation toward zero.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start_valid/ready   request handshake; dividend/divisor sampled at accept
//   out_valid/ready     response handshake
//   quotient, remainder result, stable while out_valid
//   div_by_zero         result flag, qualified by out_valid
module seq_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned AW = WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t           r_state;
  logic [AW-1:0]    r_rem;        // signed partial remainder
  logic [WIDTH-1:0] r_q;          // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_cnt;
  logic             r_start_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;
`ifdef DIV_SIGNED_EN
  logic             r_neg_q;
  logic             r_neg_r;
`endif

  // Full carry-lookahead: every carry is formed directly from g/p/cin.
  function automatic logic [AW-1:0] cla_add(input logic [AW-1:0] a,
                                            input logic [AW-1:0] b,
                                            input logic          cin);
    logic [AW-1:0] g;
    logic [AW-1:0] p;
    logic [AW-1:0] c;
    logic          pp;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < int'(AW) - 1; i++) begin
      c[i+1] = g[i];
      pp     = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp     = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & cin);
    end
    return p ^ c;
  endfunction

  logic             w_fix;
  logic             w_sub;
  logic [AW-1:0]    w_d_ext;
  logic [AW-1:0]    w_add_a;
  logic [AW-1:0]    w_add_b;
  logic [AW-1:0]    w_sum;
  logic [AW-1:0]    w_rem_fix;
  logic [WIDTH-1:0] w_a_load;
  logic [WIDTH-1:0] w_b_load;
  logic [WIDTH-1:0] w_q_final;
  logic [WIDTH-1:0] w_r_final;

  // RUN: shifted R -/+ D depending on sign of R. FIX: R + D (used only when R < 0).
  assign w_fix     = (r_state == S_FIX);
  assign w_sub     = ~w_fix & ~r_rem[WIDTH];
  assign w_d_ext   = {1'b0, r_d};
  assign w_add_a   = w_fix ? r_rem : {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_add_b   = w_sub ? ~w_d_ext : w_d_ext;
  assign w_sum     = cla_add(w_add_a, w_add_b, w_sub);
  assign w_rem_fix = r_rem[WIDTH] ? w_sum : r_rem;

`ifdef DIV_SIGNED_EN
  // Divide magnitudes, then restore signs; -2^(W-1) magnitude is exact as unsigned.
  assign w_a_load  = dividend[WIDTH-1] ? -dividend : dividend;
  assign w_b_load  = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign w_q_final = r_neg_q ? -r_q : r_q;
  assign w_r_final = r_neg_r ? -w_rem_fix[WIDTH-1:0] : w_rem_fix[WIDTH-1:0];
`else
  assign w_a_load  = dividend;
  assign w_b_load  = divisor;
  assign w_q_final = r_q;
  assign w_r_final = w_rem_fix[WIDTH-1:0];
`endif

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_rem         <= '0;
      r_q           <= '0;
      r_d           <= '0;
      r_cnt         <= '0;
      r_start_ready <= 1'b1;
      r_out_valid   <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_dbz         <= 1'b0;
`ifdef DIV_SIGNED_EN
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_valid && r_start_ready) begin
            r_start_ready <= 1'b0;
            if (divisor == '0) begin
              r_quotient  <= '1;
              r_remainder <= dividend;
              r_dbz       <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_rem   <= '0;
              r_q     <= w_a_load;
              r_d     <= w_b_load;
              r_cnt   <= '0;
`ifdef DIV_SIGNED_EN
              r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              r_neg_r <= dividend[WIDTH-1];
`endif
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_rem <= w_sum;
          r_q   <= {r_q[WIDTH-2:0], ~w_sum[WIDTH]};
          if (r_cnt != CW'(WIDTH)) begin
            r_cnt <= r_cnt + CW'(1);
          end
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_rem       <= w_rem_fix;
          r_quotient  <= w_q_final;
          r_remainder <= w_r_final;
          r_dbz       <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid   <= 1'b0;
            r_start_ready <= 1'b1;
            r_state       <= S_IDLE;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_start_ready <= 1'b1;
          r_out_valid   <= 1'b0;
        end
      endcase
    end
  end

  assign start_ready = r_start_ready;
  assign out_valid   = r_out_valid;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks for seq_divider at WIDTH = 16.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_seq_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         start_ready;
  logic         out_valid;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;
  int mon_acc = 0;
  int mon_hs = 0;
  bit mon_en = 1'b0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Handshake counters; a handshake happens at the next rising edge.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (start_valid && start_ready) mon_acc++;
      if (out_valid && out_ready) mon_hs++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend    = a;
    divisor     = b;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
  endtask

  // Edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (b == '0) return {16'hFFFF, a, 1'b1};
`ifdef DIV_SIGNED_EN
    if (a == 16'h8000 && b == 16'hFFFF) return {16'h8000, 16'h0000, 1'b0};
    q = W'($signed(a) / $signed(b));
    r = W'($signed(a) % $signed(b));
`else
    q = a / b;
    r = a % b;
`endif
    return {q, r, 1'b0};
  endfunction

  task automatic test_reset();
    tick();
    n_cmp++;
    if ({start_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_in: got sr=%b ov=%b q=%h r=%h dz=%b want sr=1 ov=0 q=0 r=0 dz=0",
               start_ready, out_valid, quotient, remainder, div_by_zero);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({start_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_out: got sr=%b ov=%b q=%h r=%h dz=%b want sr=1 ov=0 q=0 r=0 dz=0",
               start_ready, out_valid, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_basic();
    int  n;
    bit  sr_bad;
    send(16'd100, 16'd7);
    n = 0;
    sr_bad = 1'b0;
    while (out_valid !== 1'b1 && n < 200) begin
      if (start_ready !== 1'b0) sr_bad = 1'b1;
      tick();
      n++;
    end
    if (start_ready !== 1'b0) sr_bad = 1'b1;
    n_cmp++;
    if (n != W + 1) begin
      n_bad++;
      $display("FAIL basic_latency: got %0d edges want %0d", n, W + 1);
    end
    n_cmp++;
    if (sr_bad) begin
      n_bad++;
      $display("FAIL basic_start_ready: got high while busy want low");
    end
    n_cmp++;
    if ({quotient, remainder, div_by_zero} !== {16'd14, 16'd2, 1'b0}) begin
      n_bad++;
      $display("FAIL basic_100_7: got q=%0d r=%0d dz=%b want q=14 r=2 dz=0", quotient, remainder, div_by_zero);
    end
    release_result();
    n_cmp++;
    if ({out_valid, start_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL basic_handshake: got ov=%b sr=%b want ov=0 sr=1", out_valid, start_ready);
    end
  endtask

  task automatic test_div_zero();
    int n;
    send(16'h04D2, 16'h0000);
    wait_valid(n);
    n_cmp++;
    if (n != 0) begin
      n_bad++;
      $display("FAIL dz_latency: got %0d edges want 0", n);
    end
    n_cmp++;
    if ({quotient, remainder, div_by_zero} !== {16'hFFFF, 16'h04D2, 1'b1}) begin
      n_bad++;
      $display("FAIL dz_values: got q=%h r=%h dz=%b want q=ffff r=04d2 dz=1", quotient, remainder, div_by_zero);
    end
    release_result();
  endtask

  task automatic test_boundary_and_stall();
    int             n;
    bit             st_bad;
    logic [2*W:0]   hold;
    send(16'hFFFF, 16'h0001);
    wait_valid(n);
    n_cmp++;
    if ({quotient, remainder, div_by_zero} !== {16'hFFFF, 16'h0000, 1'b0} || n != W + 1) begin
      n_bad++;
      $display("FAIL max_by_1: got q=%h r=%h dz=%b lat=%0d want q=ffff r=0000 dz=0 lat=%0d",
               quotient, remainder, div_by_zero, n, W + 1);
    end
    release_result();
    send(16'd5, 16'd9);
    wait_valid(n);
    n_cmp++;
    if ({quotient, remainder, div_by_zero} !== {16'd0, 16'd5, 1'b0}) begin
      n_bad++;
      $display("FAIL small_5_9: got q=%0d r=%0d dz=%b want q=0 r=5 dz=0", quotient, remainder, div_by_zero);
    end
    hold = {quotient, remainder, div_by_zero};
    st_bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      start_valid = ~start_valid;
      dividend    = W'($urandom);
      divisor     = W'($urandom);
      tick();
      if ({quotient, remainder, div_by_zero} !== hold || out_valid !== 1'b1 || start_ready !== 1'b0)
        st_bad = 1'b1;
    end
    n_cmp++;
    if (st_bad) begin
      n_bad++;
      $display("FAIL stall_hold: got q=%h r=%h ov=%b sr=%b want q=0000 r=0005 ov=1 sr=0",
               quotient, remainder, out_valid, start_ready);
    end
    dividend    = 16'd9;
    divisor     = 16'd3;
    start_valid = 1'b1;
    out_ready   = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if ({out_valid, start_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL stall_release: got ov=%b sr=%b want ov=0 sr=1", out_valid, start_ready);
    end
    tick();
    start_valid = 1'b0;
    n_cmp++;
    if (start_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_accept: got sr=%b want 0", start_ready);
    end
    wait_valid(n);
    n_cmp++;
    if ({quotient, remainder, div_by_zero} !== {16'd3, 16'd0, 1'b0} || n != W + 1) begin
      n_bad++;
      $display("FAIL b2b_9_3: got q=%0d r=%0d dz=%b lat=%0d want q=3 r=0 dz=0 lat=%0d",
               quotient, remainder, div_by_zero, n, W + 1);
    end
    release_result();
  endtask

  task automatic test_reset_mid_run();
    int n;
    bit ov_seen;
    send(16'd1234, 16'd5);
    for (int i = 0; i < 6; i++) tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({start_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL midrst_values: got sr=%b ov=%b q=%h r=%h dz=%b want sr=1 ov=0 q=0 r=0 dz=0",
               start_ready, out_valid, quotient, remainder, div_by_zero);
    end
    tick();
    tick();
    rst_n = 1'b1;
    ov_seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (out_valid !== 1'b0) ov_seen = 1'b1;
    end
    n_cmp++;
    if (ov_seen) begin
      n_bad++;
      $display("FAIL midrst_discard: got out_valid=1 after reset want 0");
    end
    send(16'd1000, 16'd10);
    wait_valid(n);
    n_cmp++;
    if ({quotient, remainder, div_by_zero} !== {16'd100, 16'd0, 1'b0} || n != W + 1) begin
      n_bad++;
      $display("FAIL midrst_1000_10: got q=%0d r=%0d dz=%b lat=%0d want q=100 r=0 dz=0 lat=%0d",
               quotient, remainder, div_by_zero, n, W + 1);
    end
    release_result();
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    int n;
    send(16'hFFF9, 16'h0002);
    wait_valid(n);
    n_cmp++;
    if ({quotient, remainder, div_by_zero} !== {16'hFFFD, 16'hFFFF, 1'b0} || n != W + 1) begin
      n_bad++;
      $display("FAIL signed_m7_2: got q=%h r=%h dz=%b lat=%0d want q=fffd r=ffff dz=0", quotient, remainder, div_by_zero, n);
    end
    release_result();
    send(16'h0007, 16'hFFFE);
    wait_valid(n);
    n_cmp++;
    if ({quotient, remainder, div_by_zero} !== {16'hFFFD, 16'h0001, 1'b0}) begin
      n_bad++;
      $display("FAIL signed_7_m2: got q=%h r=%h dz=%b want q=fffd r=0001 dz=0", quotient, remainder, div_by_zero);
    end
    release_result();
    send(16'h8000, 16'hFFFF);
    wait_valid(n);
    n_cmp++;
    if ({quotient, remainder, div_by_zero} !== {16'h8000, 16'h0000, 1'b0}) begin
      n_bad++;
      $display("FAIL signed_ovf: got q=%h r=%h dz=%b want q=8000 r=0000 dz=0", quotient, remainder, div_by_zero);
    end
    release_result();
  endtask
`endif

  task automatic test_random();
    int           n;
    int           mode;
    int           exp_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2*W:0] exp_v;
    mon_acc = 0;
    mon_hs  = 0;
    mon_en  = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      a    = W'($urandom);
      mode = $urandom_range(0, 9);
      if (mode == 0)      b = '0;
      else if (mode <= 3) b = W'($urandom_range(1, 15));
      else                b = W'($urandom);
      exp_v = ref_div(a, b);
      exp_n = (b == '0) ? 0 : W + 1;
      send(a, b);
      wait_valid(n);
      n_cmp++;
      if ({quotient, remainder, div_by_zero} !== exp_v || n != exp_n) begin
        n_bad++;
        $display("FAIL rand_%0d %h/%h: got q=%h r=%h dz=%b lat=%0d want q=%h r=%h dz=%b lat=%0d",
                 k, a, b, quotient, remainder, div_by_zero, n,
                 exp_v[2*W:W+1], exp_v[W:1], exp_v[0], exp_n);
      end
      for (int s = $urandom_range(0, 3); s > 0; s--) tick();
      release_result();
    end
    tick();
    mon_en = 1'b0;
    n_cmp++;
    if (mon_acc != 2000 || mon_hs != 2000) begin
      n_bad++;
      $display("FAIL rand_handshakes: got accepts=%0d results=%0d want 2000 and 2000", mon_acc, mon_hs);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_boundary_and_stall();
    test_reset_mid_run();
`ifdef DIV_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential radix-2 non-restoring unsigned divider: the inverse-operation companion to the team's carry-lookahead adder datapath. It takes a dividend and a divisor through a valid/ready request port. It produces one quotient bit per clock using a single WIDTH+1-bit add/subtract stage. Results are returned through a valid/ready response port. It sits behind the ALU issue logic as a multi-cycle execution unit.

## Interface
- WIDTH, 16, operand/result width in bits (>= 4).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset; all state cleared immediately on assertion.
- start_valid  input  1  request valid.
- start_ready  output  1  high only in IDLE; a request is accepted on an edge where start_valid & start_ready.
- dividend  input  WIDTH  sampled at accept.
- divisor  input  WIDTH  sampled at accept.
- out_valid  output  1  result valid (DONE state).
- out_ready  input  1  consumer accepts the result on an edge where out_valid & out_ready.
- quotient  output  WIDTH  result quotient; stable while out_valid.
- remainder  output  WIDTH  result remainder; stable while out_valid.
- div_by_zero  output  1  result flag; qualified by out_valid.

## Operation
- States: IDLE, RUN, FIX, DONE.
- Reset: state = IDLE; start_ready = 1; out_valid = 0; quotient = 0; remainder = 0; div_by_zero = 0; step counter = 0.
- IDLE -> RUN on accept with divisor != 0.
  - Load partial remainder R (WIDTH+1 bits, signed) = 0.
  - Load quotient shift register Q = dividend.
  - Load divisor register D.
  - Clear the counter.
- IDLE -> DONE on accept with divisor == 0.
  - Outputs: quotient = all ones, remainder = dividend, div_by_zero = 1.
- RUN, once per cycle:
  - Form {R,Q} << 1.
  - If R >= 0, subtract D from the shifted R; otherwise add D.
  - The new quotient LSB is the inverted sign of the new R.
  - The counter increments. After WIDTH iterations the state moves to FIX.
- FIX: if R < 0, then R += D; remainder = R[WIDTH-1:0]; quotient = Q; div_by_zero = 0; -> DONE.
- DONE: out_valid = 1; outputs frozen. On out_valid & out_ready -> IDLE.
- start_valid is ignored outside IDLE. Requests are not queued.
- The add/sub stage is one WIDTH+1-bit carry-lookahead adder, with subtraction done as addition of ~D plus carry-in 1. There is no other arithmetic in the datapath except the counter.

## Timing
- Accept edge = edge 0.
- divisor != 0:
  - RUN occupies edges 1..WIDTH.
  - FIX occurs at edge WIDTH+1.
  - out_valid is high after edge WIDTH+1 and is sampled valid in cycle WIDTH+2. Latency is WIDTH+2 cycles (18 at WIDTH=16).
- divisor == 0: out_valid is high after edge 0; latency is 1 cycle.
- start_ready drops after edge 0 and returns high the edge after the result handshake. Back-to-back throughput is one request per latency+1 cycles.
- Handshake rules:
  - out_valid stays high until handshake and never deasserts without out_ready.
  - quotient, remainder and div_by_zero are held unchanged while stalled.
- Reset mid-operation (any state): immediate return to reset values. The in-flight result is discarded and no out_valid pulse is produced.
- The counter saturates at WIDTH. There is no wrap-around.

## Configuration
- DIV_SIGNED_EN defined:
  - Operands are two's complement.
  - IDLE stores the operand signs and loads magnitudes.
  - FIX additionally negates the quotient if the signs differ, and negates the remainder if the dividend is negative (truncation toward zero).
  - Overflow case most-negative / -1: quotient = most-negative, remainder = 0, div_by_zero = 0.
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Latency is unchanged.
- Undefined: unsigned only; no sign logic is synthesized.

## Test plan
- WIDTH=16, 100/7 -> quotient=14, remainder=2, div_by_zero=0; out_valid first high exactly 18 cycles after the accept edge; start_ready low throughout.
- 0x04D2/0 -> quotient=0xFFFF, remainder=0x04D2, div_by_zero=1, out_valid 1 cycle after accept.
- 0xFFFF/1 -> quotient=0xFFFF, remainder=0; 5/9 -> quotient=0, remainder=5; hold out_ready low 6 cycles while toggling start_valid and the operands -> outputs stable, no accept until 1 cycle after the handshake.
- Assert rst_n low at RUN cycle 7 -> all outputs at reset values immediately; after release, 1000/10 -> quotient=100, remainder=0 with normal latency.
- DIV_SIGNED_EN: -7/2 -> quotient=0xFFFD, remainder=0xFFFF; 7/-2 -> quotient=0xFFFD, remainder=1; 0x8000/0xFFFF -> quotient=0x8000, remainder=0.
- 2000 random operand pairs with random out_ready stalls -> every result matches the reference model, with exactly one out_valid handshake per accepted request.
